// File: rtl/wb_buffer.sv
// wb_buffer: write-back line buffer between the dmem cache and the memory arbiter.
// Evicted lines are queued in a small FIFO and drained to the arbiter in order.
// Reads that hit a buffered line are answered locally; read misses go straight
// to the arbiter and take priority over draining.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no arbiter access in flight
// S_READ  | read miss forwarded to arbiter, response passed through
// S_WRITE | head line being written to arbiter, popped on p_resp
module wb_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  c_address,
    input  logic         c_read,
    input  logic         c_write,
    input  logic [255:0] c_wdata,
    output logic [255:0] c_rdata,
    output logic         c_resp,
    output logic [31:0]  p_address,
    output logic         p_read,
    output logic         p_write,
    output logic [255:0] p_wdata,
    input  logic [255:0] p_rdata,
    input  logic         p_resp,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DEPTH-1:0] r_valid;
    logic [26:0]      r_tag  [DEPTH];
    logic [255:0]     r_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_resp;
    logic [255:0]     r_rdata;

    logic [26:0]      w_line;
    logic             w_rhit;
    logic [PW-1:0]    w_ridx;
    logic             w_whit;
    logic [PW-1:0]    w_widx;
    logic             w_full;
    logic             w_pop;
    logic             w_head_blk;
    logic             w_wr_req;
    logic             w_wr_coal;
    logic             w_wr_push;
    logic             w_rd_hit;
    logic             w_rd_miss;
    logic             w_unused;

    assign w_line   = c_address[31:5];
    assign w_unused = &{1'b0, c_address[4:0]};

    // Tag lookup in age order so the youngest matching entry wins; the head
    // being drained is not a coalesce target, but it still serves read hits.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx  = '0;
        w_rhit = 1'b0;
        w_ridx = '0;
        w_whit = 1'b0;
        w_widx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + PW'(k);
            if (r_valid[v_idx] && (r_tag[v_idx] == w_line)) begin
                w_rhit = 1'b1;
                w_ridx = v_idx;
                if (!((r_state == S_WRITE) && (v_idx == r_head))) begin
                    w_whit = 1'b1;
                    w_widx = v_idx;
                end
            end
        end
    end

    // r_resp masks the response cycle so a still-held request is not taken twice.
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = (r_state == S_WRITE) && p_resp;
    assign w_head_blk = (r_state == S_WRITE) && r_valid[r_head] && (r_tag[r_head] == w_line);
    assign w_wr_req   = c_write && !r_resp;
    assign w_wr_coal  = w_wr_req && w_whit;
    assign w_wr_push  = w_wr_req && !w_whit && (w_pop || (!w_head_blk && !w_full));
    assign w_rd_hit   = c_read && !r_resp && w_rhit && (r_state != S_READ);
    assign w_rd_miss  = c_read && !r_resp && !w_rhit;

    // FIFO storage, pointers, occupancy and the registered cache response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_resp  <= 1'b0;
            r_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_resp <= w_wr_coal || w_wr_push || w_rd_hit;
            if (w_rd_hit) begin
                r_rdata <= r_data[w_ridx];
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
            end
            if (w_wr_coal) begin
                r_data[w_widx] <= c_wdata;
            end
            // A push into a full buffer lands on the slot the pop just freed.
            if (w_wr_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tag[r_tail]   <= w_line;
                r_data[r_tail]  <= c_wdata;
                r_tail          <= (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
            end
            if (w_wr_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Downstream FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and arbiter-side outputs; read misses beat draining.
    always_comb begin
        w_state_nxt = r_state;
        p_read      = 1'b0;
        p_write     = 1'b0;
        p_address   = '0;
        p_wdata     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_miss) begin
                    w_state_nxt = S_READ;
                end else if (r_count != '0) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_READ: begin
                p_read    = 1'b1;
                p_address = {w_line, 5'b0};
                if (p_resp) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                p_write   = 1'b1;
                p_address = {r_tag[r_head], 5'b0};
                p_wdata   = r_data[r_head];
                if (p_resp) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign c_resp  = r_resp || ((r_state == S_READ) && p_resp);
    assign c_rdata = (r_state == S_READ) ? p_rdata : r_rdata;
    assign empty   = (r_count == '0) && (r_state == S_IDLE);

    a_cache_rw_excl : assert property (@(posedge clk) disable iff (!reset_n) !(c_read && c_write));
    a_arb_rw_excl   : assert property (@(posedge clk) disable iff (!reset_n) !(p_read && p_write));

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: directed cache traffic, a latency-controlled arbiter
// model with a backing memory, and a line-level reference model (FIFO of
// pending lines plus the latest value written per line) checked every cycle.
module tb_wb_buffer;

    logic         clk;
    logic         reset_n;
    logic [31:0]  c_address;
    logic         c_read;
    logic         c_write;
    logic [255:0] c_wdata;
    logic [255:0] c_rdata;
    logic         c_resp;
    logic [31:0]  p_address;
    logic         p_read;
    logic         p_write;
    logic [255:0] p_wdata;
    logic [255:0] p_rdata;
    logic         p_resp;
    logic         empty;

    wb_buffer #(.DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_address(c_address), .c_read(c_read), .c_write(c_write),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_resp(c_resp),
        .p_address(p_address), .p_read(p_read), .p_write(p_write),
        .p_wdata(p_wdata), .p_rdata(p_rdata), .p_resp(p_resp),
        .empty(empty)
    );

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
    } line_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } ev_t;

    line_t        q[$];
    ev_t          ev[$];
    logic [255:0] shadow [logic [26:0]];
    logic [255:0] mem    [logic [26:0]];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int pop_cyc  = -100;
    int resp_gap = 0;
    int pw_cycles = 0;
    int pr_cycles = 0;
    bit arb_hold = 0;
    int arb_lat  = 1;

    localparam logic [255:0] DA = {8{32'hAAAA_0001}};
    localparam logic [255:0] DB = {8{32'hBBBB_0002}};
    localparam logic [255:0] DC = {8{32'hCCCC_0003}};
    localparam logic [255:0] DD = {8{32'hDDDD_0004}};
    localparam logic [255:0] DE = {8{32'hEEEE_0005}};
    localparam logic [255:0] DF = {8{32'hFFFF_0006}};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Unwritten memory lines read back as their own address replicated.
    function automatic logic [255:0] pat(input logic [26:0] ln);
        return {8{{ln, 5'b0}}};
    endfunction

    function automatic logic [255:0] mem_rd(input logic [26:0] ln);
        if (mem.exists(ln)) return mem[ln];
        return pat(ln);
    endfunction

    function automatic logic [255:0] exp_rd(input logic [26:0] ln);
        if (shadow.exists(ln)) return shadow[ln];
        return mem_rd(ln);
    endfunction

    function automatic bit in_q(input logic [26:0] ln);
        for (int i = 0; i < q.size(); i++)
            if (q[i].tag == ln) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input logic [26:0] ln, input logic [255:0] d);
        bit found;
        line_t e;
        found = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == ln) begin
                q[i].data = d;
                found = 1;
            end
        end
        if (!found) begin
            e.tag  = ln;
            e.data = d;
            q.push_back(e);
        end
        shadow[ln] = d;
    endtask

    // Arbiter: answers each request after arb_lat waiting cycles unless held.
    initial begin
        int wc;
        wc = 0;
        p_resp  = 0;
        p_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            p_resp = 0;
            if (reset_n && (p_read || p_write) && !arb_hold) begin
                if (wc >= arb_lat) begin
                    p_resp  = 1;
                    p_rdata = p_read ? mem_rd(p_address[31:5]) : '0;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Per-cycle comparison against the line-level model.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("p_rw_excl", {255'b0, p_read & p_write}, '0);
                chk("resp_without_req", {255'b0, c_resp & ~(c_read | c_write)}, '0);
                if (c_resp && c_read)
                    chk("rd_data", c_rdata, exp_rd(c_address[31:5]));
                if (c_resp && c_write) begin
                    model_write(c_address[31:5], c_wdata);
                    resp_gap = cyc - pop_cyc;
                end
                if (q.size() > DEPTH_MAX()) chk("model_overflow", q.size(), DEPTH_MAX());
                if (p_write) begin
                    pw_cycles++;
                    if (q.size() == 0) begin
                        chk("p_write_unexpected", {255'b0, p_write}, '0);
                    end else begin
                        chk("p_write_addr", p_address, {q[0].tag, 5'b0});
                        chk("p_write_data", p_wdata, q[0].data);
                        if (p_resp) begin
                            mem[q[0].tag] = p_wdata;
                            e.wr = 1; e.addr = p_address; e.data = p_wdata;
                            ev.push_back(e);
                            void'(q.pop_front());
                            pop_cyc = cyc;
                        end
                    end
                end
                if (p_read) begin
                    pr_cycles++;
                    chk("p_read_addr", p_address, {c_address[31:5], 5'b0});
                    chk("p_read_on_buffered_line", {255'b0, in_q(c_address[31:5])}, '0);
                    chk("p_read_resp_passthru", {255'b0, c_resp}, {255'b0, p_resp});
                    if (p_resp) begin
                        chk("p_read_data_passthru", c_rdata, p_rdata);
                        e.wr = 0; e.addr = p_address; e.data = p_rdata;
                        ev.push_back(e);
                    end
                end
                if (q.size() > 0) chk("empty_with_lines", {255'b0, empty}, '0);
            end
        end
    end

    function automatic int DEPTH_MAX();
        return 2;
    endfunction

    task automatic cache_write(input logic [31:0] a, input logic [255:0] d, output int n);
        @(posedge clk);
        #1;
        c_address = a;
        c_wdata   = d;
        c_write   = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_resp && n < 300);
        if (!c_resp) chk("write_timeout", {255'b0, c_resp}, 256'd1);
        @(posedge clk);
        #1;
        c_write = 0;
    endtask

    task automatic cache_read(input logic [31:0] a, output logic [255:0] d, output int n);
        @(posedge clk);
        #1;
        c_address = a;
        c_read    = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_resp && n < 300);
        if (!c_resp) chk("read_timeout", {255'b0, c_resp}, 256'd1);
        d = c_rdata;
        @(posedge clk);
        #1;
        c_read = 0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(empty && q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", {255'b0, empty}, 256'd1);
    endtask

    task automatic chk_ev(input string nm, input int i, input bit wr, input logic [31:0] a,
                          input logic [255:0] d);
        if (i < ev.size()) begin
            chk({nm, "_kind"}, {255'b0, ev[i].wr}, {255'b0, wr});
            chk({nm, "_addr"}, ev[i].addr, a);
            chk({nm, "_data"}, ev[i].data, d);
        end else begin
            chk({nm, "_missing"}, ev.size(), i + 1);
        end
    endtask

    initial begin
        int n;
        int pr0;
        int pw0;
        logic [255:0] d;

        reset_n = 0; c_address = 0; c_read = 0; c_write = 0; c_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_c_resp",   {255'b0, c_resp},  '0);
        chk("rst_p_read",   {255'b0, p_read},  '0);
        chk("rst_p_write",  {255'b0, p_write}, '0);
        chk("rst_empty",    {255'b0, empty},   256'd1);
        chk("rst_c_rdata",  c_rdata,   '0);
        chk("rst_p_addr",   p_address, '0);
        chk("rst_p_wdata",  p_wdata,   '0);
        reset_n = 1;

        // push then drain in order
        arb_hold = 1;
        cache_write(32'h100, DA, n); chk("t1_wr1_lat", n, 2);
        cache_write(32'h200, DB, n); chk("t1_wr2_lat", n, 2);
        @(negedge clk);
        chk("t1_p_write_held", {255'b0, p_write}, 256'd1);
        chk("t1_head_addr", p_address, 32'h100);
        arb_hold = 0;
        wait_drain(60);
        chk("t1_ev_count", ev.size(), 2);
        chk_ev("t1_ev0", 0, 1, 32'h100, DA);
        chk_ev("t1_ev1", 1, 1, 32'h200, DB);
        ev.delete();

        // read hit served from the head while it is being drained
        arb_hold = 1;
        pr0 = pr_cycles;
        cache_write(32'h100, DA, n);
        cache_read(32'h11F, d, n);
        chk("t2_rd_lat", n, 2);
        chk("t2_rd_data", d, DA);
        chk("t2_no_p_read", pr_cycles, pr0);
        arb_hold = 0;
        wait_drain(60);
        ev.delete();

        // read miss waits for the current write, then beats the next drain
        arb_hold = 1;
        cache_write(32'h100, DA, n);
        cache_write(32'h200, DB, n);
        fork
            cache_read(32'h31C, d, n);
            begin
                repeat (4) @(posedge clk);
                #2 arb_hold = 0;
            end
        join
        chk("t3_rd_data", d, {8{32'h0000_0300}});
        wait_drain(60);
        chk("t3_ev_count", ev.size(), 3);
        chk_ev("t3_ev0", 0, 1, 32'h100, DA);
        chk_ev("t3_ev1", 1, 0, 32'h300, {8{32'h0000_0300}});
        chk_ev("t3_ev2", 2, 1, 32'h200, DB);
        ev.delete();

        // full: coalesce accepted, new line stalls until the head pops
        arb_hold = 1;
        cache_write(32'h100, DA, n);
        cache_write(32'h200, DB, n);
        cache_write(32'h200, DC, n); chk("t4_coalesce_lat", n, 2);
        fork
            cache_write(32'h400, DD, n);
            begin
                repeat (6) @(posedge clk);
                #2 arb_hold = 0;
            end
        join
        chk("t4_stalled", {255'b0, (n > 4)}, 256'd1);
        chk("t4_push_at_pop", resp_gap, 1);
        wait_drain(80);
        chk("t4_ev_count", ev.size(), 3);
        chk_ev("t4_ev0", 0, 1, 32'h100, DA);
        chk_ev("t4_ev1", 1, 1, 32'h200, DC);
        chk_ev("t4_ev2", 2, 1, 32'h400, DD);
        ev.delete();

        // write to the line being drained allocates a fresh entry after the pop
        arb_hold = 1;
        cache_write(32'h100, DA, n);
        fork
            cache_write(32'h100, DE, n);
            begin
                repeat (5) @(posedge clk);
                #2 arb_hold = 0;
            end
        join
        chk("t5_stalled", {255'b0, (n > 4)}, 256'd1);
        chk("t5_push_at_pop", resp_gap, 1);
        wait_drain(60);
        chk("t5_ev_count", ev.size(), 2);
        chk_ev("t5_ev0", 0, 1, 32'h100, DA);
        chk_ev("t5_ev1", 1, 1, 32'h100, DE);
        ev.delete();

        // reset while a line is being written out
        arb_hold = 1;
        cache_write(32'h500, DF, n);
        @(negedge clk);
        chk("t6_p_write_before", {255'b0, p_write}, 256'd1);
        #2 reset_n = 0;
        #1;
        chk("t6_p_write_async", {255'b0, p_write}, '0);
        chk("t6_empty_async", {255'b0, empty}, 256'd1);
        chk("t6_p_addr_async", p_address, '0);
        for (int i = 0; i < q.size(); i++) begin
            if (mem.exists(q[i].tag)) shadow[q[i].tag] = mem[q[i].tag];
            else shadow.delete(q[i].tag);
        end
        q.delete();
        pw0 = pw_cycles;
        repeat (2) @(negedge clk);
        reset_n = 1;
        arb_hold = 0;
        repeat (10) @(negedge clk);
        chk("t6_no_p_write", pw_cycles, pw0);
        chk("t6_empty_after", {255'b0, empty}, 256'd1);
        cache_read(32'h500, d, n);
        chk("t6_line_discarded", d, {8{32'h0000_0500}});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
